// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and
// the instruction memory; the memory may insert any number of wait states.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ack
// port, and drives the IF/ID register with stall, redirect and bubble handling.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       new_pc_i,
    if_stage_if.master        imem,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD,
        DRAIN
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    state_e      state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_pc_q,     buf_pc_d;
    logic [31:0] buf_inst_q,   buf_inst_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] inst_q,       inst_d;

    // While draining, the bus must keep presenting the abandoned address
    // until the memory acknowledges it.
    assign imem.req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem.addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;

    assign pc_o   = pc_q;
    assign inst_o = inst_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        pc_d         = pc_q;
        inst_d       = inst_q;

        if (flush_i) begin
            // Redirect wins over stall: decode sees a bubble and pc_o is kept.
            fetch_pc_d = {new_pc_i[31:2], 2'b00};
            inst_d     = NOP;
            if ((state_q == FETCH || state_q == DRAIN) && !imem.ack) begin
                state_d = DRAIN;
                if (state_q == FETCH) begin
                    drain_addr_d = fetch_pc_q;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                START: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem.ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (stall_i) begin
                            buf_pc_d   = fetch_pc_q;
                            buf_inst_d = imem.rdata;
                            state_d    = HOLD;
                        end else begin
                            pc_d   = fetch_pc_q;
                            inst_d = imem.rdata;
                        end
                    end else if (!stall_i) begin
                        inst_d = NOP;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        pc_d    = buf_pc_q;
                        inst_d  = buf_inst_q;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.ack) begin
                        state_d = FETCH;
                    end
                    if (!stall_i) begin
                        inst_d = NOP;
                    end
                end
                default: begin
                    state_d = START;
                end
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= START;
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'h0;
            inst_q     <= NOP;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    // NOTE: the skid buffer and drain address carry no reset; each is written
    // before the state that reads it can be entered.
    always_ff @(posedge clk) begin
        drain_addr_q <= drain_addr_d;
        buf_pc_q     <= buf_pc_d;
        buf_inst_q   <= buf_inst_d;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle table with zero-wait memory, then
// hand sequences for wait states, redirect during a wait, wrap-around and reset.
module tb_if_stage;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        stall0, flush0;
    logic [31:0] new_pc0;
    logic        stall1 = 1'b0;
    logic        flush1 = 1'b0;
    logic [31:0] new_pc1 = 32'h0;
    logic [31:0] pc0, inst0, pc1, inst1;

    int n_wait0 = 0, n_wait1 = 0;
    int cnt0 = 0, cnt1 = 0;
    int checks = 0, errors = 0;

    if_stage_if bus0 ();
    if_stage_if bus1 ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk      (clk),
        .rst      (rst0),
        .stall_i  (stall0),
        .flush_i  (flush0),
        .new_pc_i (new_pc0),
        .imem     (bus0),
        .pc_o     (pc0),
        .inst_o   (inst0)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .stall_i  (stall1),
        .flush_i  (flush1),
        .new_pc_i (new_pc1),
        .imem     (bus1),
        .pc_o     (pc1),
        .inst_o   (inst1)
    );

    always #5 clk = ~clk;

    // Memory model: acknowledges after n_wait cycles of a held request and
    // returns addr | A000_0000.
    assign bus0.ack   = bus0.req && (cnt0 == n_wait0);
    assign bus0.rdata = bus0.addr | 32'hA000_0000;
    assign bus1.ack   = bus1.req && (cnt1 == n_wait1);
    assign bus1.rdata = bus1.addr | 32'hA000_0000;

    always @(posedge clk) begin
        if (!bus0.req || bus0.ack) cnt0 <= 0;
        else                       cnt0 <= cnt0 + 1;
        if (!bus1.req || bus1.ack) cnt1 <= 0;
        else                       cnt1 <= cnt1 + 1;
    end

    function automatic vec_t mk(logic s, logic f, logic [31:0] np, logic r,
                                logic [31:0] a, logic [31:0] p, logic [31:0] i);
        vec_t v;
        v.stall = s; v.flush = f; v.new_pc = np;
        v.exp_req = r; v.exp_addr = a; v.exp_pc = p; v.exp_inst = i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Check outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input int dut, input string tag, input vec_t v);
        @(negedge clk);
        if (dut == 0) begin
            chk({tag, ".req"},  {31'h0, bus0.req}, {31'h0, v.exp_req});
            chk({tag, ".addr"}, bus0.addr, v.exp_addr);
            chk({tag, ".pc"},   pc0,       v.exp_pc);
            chk({tag, ".inst"}, inst0,     v.exp_inst);
            stall0  = v.stall;
            flush0  = v.flush;
            new_pc0 = v.new_pc;
        end else begin
            chk({tag, ".req"},  {31'h0, bus1.req}, {31'h0, v.exp_req});
            chk({tag, ".addr"}, bus1.addr, v.exp_addr);
            chk({tag, ".pc"},   pc1,       v.exp_pc);
            chk({tag, ".inst"}, inst1,     v.exp_inst);
        end
    endtask

    vec_t vecs [16];

    initial begin
        //            stall flush new_pc        req  addr          pc            inst
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h00, 32'h000, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h00, 32'h000, 32'h0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h04, 32'h000, 32'hA000_0000);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h08, 32'h004, 32'hA000_0004);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0C, 32'h004, 32'hA000_0004);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0C, 32'h004, 32'hA000_0004);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0C, 32'h004, 32'hA000_0004);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0C, 32'h008, 32'hA000_0008);
        vecs[8]  = mk(1'b0, 1'b1, 32'h103, 1'b1, 32'h10, 32'h00C, 32'hA000_000C);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00C, 32'h0);
        vecs[10] = mk(1'b1, 1'b1, 32'h20,  1'b1, 32'h104, 32'h100, 32'hA000_0100);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h20, 32'h100, 32'h0);
        vecs[12] = mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h24, 32'h100, 32'h0);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 32'h100, 32'h0);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h44, 32'h040, 32'hA000_0040);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h48, 32'h044, 32'hA000_0044);

        // NOTE: bench inputs are driven with blocking assignments away from
        // the rising edge, so the DUT samples settled values.
        rst0 = 1'b1; rst1 = 1'b1;
        stall0 = 1'b0; flush0 = 1'b0; new_pc0 = 32'h0;
        repeat (2) @(posedge clk);

        // Zero-wait stream, stall/hold/release, flush at ack, flush with stall, flush in HOLD.
        for (int k = 0; k < 16; k++) begin
            step(0, $sformatf("t%0d", k), vecs[k]);
            if (k == 0) rst0 = 1'b0;
        end

        // Two wait states per fetch: address held 3 cycles, two bubbles between.
        n_wait0 = 2;
        step(0, "w16", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h48,  32'h044, 32'h0));
        step(0, "w17", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h48,  32'h044, 32'h0));
        step(0, "w18", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4C,  32'h048, 32'hA000_0048));
        step(0, "w19", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4C,  32'h048, 32'h0));
        step(0, "w20", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4C,  32'h048, 32'h0));
        // Flush during the wait of 0x50: old address held to ack, data dropped.
        step(0, "w21", mk(1'b0, 1'b1, 32'h200, 1'b1, 32'h50,  32'h04C, 32'hA000_004C));
        step(0, "d22", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h50,  32'h04C, 32'h0));
        step(0, "d23", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h50,  32'h04C, 32'h0));
        step(0, "d24", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h04C, 32'h0));
        step(0, "d25", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h04C, 32'h0));
        step(0, "d26", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h04C, 32'h0));
        step(0, "d27", mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 32'h200, 32'hA000_0200));

        // High reset PC: wrap-around to 0, then reset in the middle of a wait.
        step(1, "m0", mk(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0));
        rst1 = 1'b0;
        step(1, "m1", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0));
        step(1, "m2", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8));
        step(1, "m3", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        n_wait1 = 2;
        step(1, "m4", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0));
        rst1 = 1'b1;
        step(1, "m5", mk(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
